vx_axi_read_credit_ctrl: RTL

- Per-requester admission controller placed in front of the AXI read-channel arbiter.
- Gates each requester's AR handshake on two credits: outstanding-burst credits and read-data beat credits, the latter sized to the downstream response buffering.
- Credits are released as R beats complete.
- Also provides a flush/drain handshake and sticky protocol-error flags.

---
 rtl/vx_axi_read_credit_ctrl_pkg.sv | 38 +++
 rtl/vx_axi_read_credit_slot.sv | 86 ++++++++
 rtl/vx_axi_read_credit_ctrl.sv | 64 ++++++
 3 files changed

// File: rtl/vx_axi_read_credit_ctrl_pkg.sv
// Shared types and helpers for the AXI read credit controller.
// Counter arithmetic runs at CNT_W bits so sums never wrap before comparison.
package vx_axi_read_credit_ctrl_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    CD_NONE    = 2'd0,
    CD_ALLOC   = 2'd1,
    CD_RELEASE = 2'd2,
    CD_BOTH    = 2'd3
  } credit_delta_e;

  function automatic credit_delta_e credit_delta(input logic alloc, input logic rel);
    credit_delta_e d;
    case ({rel, alloc})
      2'b01:   d = CD_ALLOC;
      2'b10:   d = CD_RELEASE;
      2'b11:   d = CD_BOTH;
      default: d = CD_NONE;
    endcase
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] next_beats(input logic [CNT_W-1:0] cur,
                                                  input logic [CNT_W-1:0] need,
                                                  input credit_delta_e    d);
    logic [CNT_W-1:0] nxt;
    case (d)
      CD_ALLOC:   nxt = cur + need;
      CD_RELEASE: nxt = cur - CNT_W'(1);
      CD_BOTH:    nxt = cur + need - CNT_W'(1);
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vx_axi_read_credit_slot.sv
// One requester's credit state: outstanding bursts, beats in use, admission
// gate and sticky protocol-error flags.
module vx_axi_read_credit_slot
  import vx_axi_read_credit_ctrl_pkg::*;
#(
  parameter int MAX_BURSTS = 4,
  parameter int MAX_BEATS  = 256,
  parameter int BURST_W    = $clog2(MAX_BURSTS + 1),
  parameter int BEAT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_req_i,
  input  logic       arvalid_i,
  input  logic [7:0] arlen_i,
  input  logic       arready_dn_i,
  input  logic       rsp_fire_i,
  input  logic       rsp_last_i,
  output logic       arvalid_dn_o,
  output logic       arready_up_o,
  output logic       idle_o,
  output logic       err_underflow_o,
  output logic       err_oversize_o
);

  logic [BURST_W-1:0] bursts_q, bursts_d;
  logic [BEAT_W-1:0]  beats_q, beats_d;
  logic               err_uf_q, err_uf_d;
  logic               err_os_q, err_os_d;

  logic [CNT_W-1:0] need;
  logic             oversize, burst_ok, beat_ok, allow, grant;
  logic             beat_rel, beat_uf, burst_rel, burst_uf;
  credit_delta_e    beat_delta, burst_delta;

  assign need     = CNT_W'(arlen_i) + CNT_W'(1);
  assign oversize = need > CNT_W'(MAX_BEATS);
  assign burst_ok = CNT_W'(bursts_q) < CNT_W'(MAX_BURSTS);
  assign beat_ok  = (CNT_W'(beats_q) + need) <= CNT_W'(MAX_BEATS);

  // Gate is purely a function of registered state, flush and arlen, so the
  // arbiter's ready never loops back into our valid.
  assign allow        = ~flush_req_i & burst_ok & beat_ok;
  assign arvalid_dn_o = arvalid_i & allow;
  assign arready_up_o = arready_dn_i & allow;
  assign grant        = arvalid_i & arready_dn_i & allow;

  // A response with no credit in use is flagged and otherwise ignored.
  assign beat_rel  = rsp_fire_i & (beats_q != '0);
  assign beat_uf   = rsp_fire_i & (beats_q == '0);
  assign burst_rel = rsp_fire_i & rsp_last_i & (bursts_q != '0);
  assign burst_uf  = rsp_fire_i & rsp_last_i & (bursts_q == '0);

  always_comb begin
    beat_delta  = credit_delta(grant, beat_rel);
    burst_delta = credit_delta(grant, burst_rel);
    beats_d     = BEAT_W'(next_beats(CNT_W'(beats_q), need, beat_delta));
    bursts_d    = bursts_q;
    case (burst_delta)
      CD_ALLOC:   bursts_d = bursts_q + BURST_W'(1);
      CD_RELEASE: bursts_d = bursts_q - BURST_W'(1);
      default:    bursts_d = bursts_q;
    endcase
    err_uf_d = err_uf_q | beat_uf | burst_uf;
    err_os_d = err_os_q | (arvalid_i & oversize);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bursts_q <= '0;
      beats_q  <= '0;
      err_uf_q <= 1'b0;
      err_os_q <= 1'b0;
    end else begin
      bursts_q <= bursts_d;
      beats_q  <= beats_d;
      err_uf_q <= err_uf_d;
      err_os_q <= err_os_d;
    end
  end

  assign idle_o          = (bursts_q == '0) & (beats_q == '0);
  assign err_underflow_o = err_uf_q;
  assign err_oversize_o  = err_os_q;

endmodule

// File: rtl/vx_axi_read_credit_ctrl.sv
// Per-requester AR admission control ahead of the read arbiter, with
// flush/drain handshake. Each requester is tracked by an independent slot.
module vx_axi_read_credit_ctrl
  import vx_axi_read_credit_ctrl_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int MAX_BURSTS = 4,
  parameter int MAX_BEATS  = 256,
  parameter int BURST_W    = $clog2(MAX_BURSTS + 1),
  parameter int BEAT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_INPUTS-1:0]      in_arvalid,
  output logic [NUM_INPUTS-1:0]      in_arready,
  input  logic [NUM_INPUTS-1:0][7:0] in_arlen,
  output logic [NUM_INPUTS-1:0]      out_arvalid,
  input  logic [NUM_INPUTS-1:0]      out_arready,
  input  logic [NUM_INPUTS-1:0]      rsp_fire,
  input  logic [NUM_INPUTS-1:0]      rsp_last,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic                       idle,
  output logic [NUM_INPUTS-1:0]      err_underflow,
  output logic [NUM_INPUTS-1:0]      err_oversize
);

  logic [NUM_INPUTS-1:0] slot_idle;
  logic                  flush_done_q, flush_done_d;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_slot
    vx_axi_read_credit_slot #(
      .MAX_BURSTS (MAX_BURSTS),
      .MAX_BEATS  (MAX_BEATS),
      .BURST_W    (BURST_W),
      .BEAT_W     (BEAT_W)
    ) u_slot (
      .clk             (clk),
      .reset           (reset),
      .flush_req_i     (flush_req),
      .arvalid_i       (in_arvalid[g]),
      .arlen_i         (in_arlen[g]),
      .arready_dn_i    (out_arready[g]),
      .rsp_fire_i      (rsp_fire[g]),
      .rsp_last_i      (rsp_last[g]),
      .arvalid_dn_o    (out_arvalid[g]),
      .arready_up_o    (in_arready[g]),
      .idle_o          (slot_idle[g]),
      .err_underflow_o (err_underflow[g]),
      .err_oversize_o  (err_oversize[g])
    );
  end

  assign idle         = &slot_idle;
  assign flush_done_d = flush_req & idle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flush_done_q <= 1'b0;
    else        flush_done_q <= flush_done_d;
  end

  assign flush_done = flush_done_q;

endmodule
